estagio_escrita: RTL and testbench

Write-back stage of the 16-bit pipeline: the producer side of the register-bank write port. It accepts a retiring instruction's result, waits on the data memory (MD) response when the instruction is a load, then drives one write-enable pulse, the 3-bit destination select and the 16-bit write data into the register bank. It also exposes the pending write so that forwarding and hazard logic can inspect it.

---
 rtl/estagio_escrita_if.sv | 31 +++
 rtl/estagio_escrita.sv | 91 +++++++++
 tb/tb_estagio_escrita.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/estagio_escrita_if.sv
// Bundle of the write-back stage: upstream handshake, MD response, register-bank
// write port and forwarding view.
interface estagio_escrita_if;
    logic        valido;
    logic        pronto;
    logic [1:0]  controle;
    logic        hab_escrita;
    logic [2:0]  sel_destino;
    logic [15:0] dado_ULA;
    logic [15:0] dado_PC;
    logic        MD_pronto;
    logic [15:0] MD_dado;
    logic        BR_Hab_Escrita;
    logic [2:0]  BR_Sel_E;
    logic [15:0] BR_E;
    logic        fwd_valido;
    logic [2:0]  fwd_sel;
    logic        erro;

    modport master (
        output valido, controle, hab_escrita, sel_destino, dado_ULA, dado_PC,
               MD_pronto, MD_dado,
        input  pronto, BR_Hab_Escrita, BR_Sel_E, BR_E, fwd_valido, fwd_sel, erro
    );

    modport slave (
        input  valido, controle, hab_escrita, sel_destino, dado_ULA, dado_PC,
               MD_pronto, MD_dado,
        output pronto, BR_Hab_Escrita, BR_Sel_E, BR_E, fwd_valido, fwd_sel, erro
    );
endinterface

// File: rtl/estagio_escrita.sv
// Write-back stage: retires ULA/PC/load results into the register bank.
// Optional macro ESCRITA_PIPE_EN lets a new instruction be accepted during ESCREVE.
module estagio_escrita #(
    parameter int unsigned ESPERA_MAX = 15
) (
    input  logic             clock,
    input  logic             reset,
    estagio_escrita_if.slave bus
);
    localparam int unsigned CW = 8;

`ifdef ESCRITA_PIPE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        OCIOSO    = 2'd0,
        ESPERA_MD = 2'd1,
        ESCREVE   = 2'd2
    } estado_t;

    estado_t       estado;
    logic [CW-1:0] cnt;
    logic          transf;
    logic          escreve_dir;
    logic          carga;
    logic [15:0]   dado_sel;

    assign bus.pronto  = (estado == OCIOSO) || (PIPE_EN && (estado == ESCREVE));
    assign transf      = bus.valido && bus.pronto;
    assign escreve_dir = transf && bus.hab_escrita &&
                         ((bus.controle == 2'b00) || (bus.controle == 2'b10));
    assign carga       = transf && bus.hab_escrita && (bus.controle == 2'b01);
    assign dado_sel    = (bus.controle == 2'b10) ? bus.dado_PC : bus.dado_ULA;

    // BR_Sel_E/BR_E double as the latched write payload; they only change on entry to ESCREVE.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado             <= OCIOSO;
            cnt                <= '0;
            bus.BR_Hab_Escrita <= 1'b0;
            bus.BR_Sel_E       <= '0;
            bus.BR_E           <= '0;
            bus.fwd_valido     <= 1'b0;
            bus.fwd_sel        <= '0;
            bus.erro           <= 1'b0;
        end else begin
            bus.BR_Hab_Escrita <= 1'b0;
            case (estado)
                OCIOSO, ESCREVE: begin
                    estado         <= OCIOSO;
                    bus.fwd_valido <= 1'b0;
                    if (escreve_dir) begin
                        estado             <= ESCREVE;
                        bus.BR_Hab_Escrita <= 1'b1;
                        bus.BR_Sel_E       <= bus.sel_destino;
                        bus.BR_E           <= dado_sel;
                        bus.fwd_sel        <= bus.sel_destino;
                        bus.fwd_valido     <= 1'b1;
                    end else if (carga) begin
                        estado         <= ESPERA_MD;
                        cnt            <= '0;
                        bus.fwd_sel    <= bus.sel_destino;
                        bus.fwd_valido <= 1'b1;
                    end
                end
                ESPERA_MD: begin
                    // A response on the final wait cycle still beats the timeout.
                    if (bus.MD_pronto) begin
                        estado             <= ESCREVE;
                        bus.BR_Hab_Escrita <= 1'b1;
                        bus.BR_Sel_E       <= bus.fwd_sel;
                        bus.BR_E           <= bus.MD_dado;
                    end else if (cnt == CW'(ESPERA_MAX - 1)) begin
                        estado         <= OCIOSO;
                        bus.erro       <= 1'b1;
                        bus.fwd_valido <= 1'b0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    estado         <= OCIOSO;
                    bus.fwd_valido <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_estagio_escrita.sv
// Randomized + directed bench for estagio_escrita against a transaction-level model.
module tb_estagio_escrita;
    localparam int unsigned ESPERA_MAX = 15;
`ifdef ESCRITA_PIPE_EN
    localparam bit PIPE_EN = 1'b1;
`else
    localparam bit PIPE_EN = 1'b0;
`endif

    logic clock;
    logic reset;
    estagio_escrita_if bus ();

    estagio_escrita #(.ESPERA_MAX(ESPERA_MAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;

    // Model: what retires this cycle and what is outstanding.
    bit          m_escreve;
    bit          m_carregando;
    int          m_esperou;
    logic [2:0]  m_fsel;
    logic [2:0]  m_ult_sel;
    logic [15:0] m_ult_dado;
    bit          m_erro;

    task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: obtido=%0h esperado=%0h (t=%0t)", tag, obs, esp, $time);
        end
    endtask

    task automatic modelo_reset();
        m_escreve    = 1'b0;
        m_carregando = 1'b0;
        m_esperou    = 0;
        m_fsel       = '0;
        m_ult_sel    = '0;
        m_ult_dado   = '0;
        m_erro       = 1'b0;
    endtask

    // One clock cycle: check current outputs, drive this cycle's inputs, advance the model.
    task automatic ciclo(input bit v, input logic [1:0] ctl, input bit hab, input logic [2:0] sel,
                         input logic [15:0] ula, input logic [15:0] pc,
                         input bit mdp, input logic [15:0] mdd);
        bit pronto_esp;
        bit nova_escrita;
        @(negedge clock);
        pronto_esp = !m_carregando && (!m_escreve || PIPE_EN);
        verifica("pronto",         32'(bus.pronto),         32'(pronto_esp));
        verifica("BR_Hab_Escrita", 32'(bus.BR_Hab_Escrita), 32'(m_escreve));
        verifica("BR_Sel_E",       32'(bus.BR_Sel_E),       32'(m_ult_sel));
        verifica("BR_E",           32'(bus.BR_E),           32'(m_ult_dado));
        verifica("fwd_valido",     32'(bus.fwd_valido),     32'(m_carregando || m_escreve));
        verifica("fwd_sel",        32'(bus.fwd_sel),        32'(m_fsel));
        verifica("erro",           32'(bus.erro),           32'(m_erro));

        bus.valido      = v;
        bus.controle    = ctl;
        bus.hab_escrita = hab;
        bus.sel_destino = sel;
        bus.dado_ULA    = ula;
        bus.dado_PC     = pc;
        bus.MD_pronto   = mdp;
        bus.MD_dado     = mdd;

        nova_escrita = 1'b0;
        if (m_carregando) begin
            if (mdp) begin
                nova_escrita = 1'b1;
                m_ult_sel    = m_fsel;
                m_ult_dado   = mdd;
                m_carregando = 1'b0;
            end else begin
                m_esperou++;
                if (m_esperou == int'(ESPERA_MAX)) begin
                    m_erro       = 1'b1;
                    m_carregando = 1'b0;
                end
            end
        end else if (v && pronto_esp && hab && ctl != 2'b11) begin
            m_fsel = sel;
            if (ctl == 2'b01) begin
                m_carregando = 1'b1;
                m_esperou    = 0;
            end else begin
                nova_escrita = 1'b1;
                m_ult_sel    = sel;
                m_ult_dado   = (ctl == 2'b10) ? pc : ula;
            end
        end
        m_escreve = nova_escrita;
    endtask

    task automatic ocioso(input int n, input bit mdp);
        for (int i = 0; i < n; i++) ciclo(1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, mdp, 16'hDEAD);
    endtask

    initial begin
        reset           = 1'b0;
        bus.valido      = 1'b0;
        bus.controle    = 2'b00;
        bus.hab_escrita = 1'b0;
        bus.sel_destino = '0;
        bus.dado_ULA    = '0;
        bus.dado_PC     = '0;
        bus.MD_pronto   = 1'b0;
        bus.MD_dado     = '0;
        modelo_reset();
        #12;
        verifica("rst_BR_Hab", 32'(bus.BR_Hab_Escrita), 32'd0);
        verifica("rst_BR_E",   32'(bus.BR_E),           32'd0);
        verifica("rst_fwd",    32'(bus.fwd_valido),     32'd0);
        verifica("rst_erro",   32'(bus.erro),           32'd0);
        @(negedge clock);
        reset = 1'b1;

        // ULA write of 1234 to r3, then PC link to r6
        ciclo(1'b1, 2'b00, 1'b1, 3'd3, 16'h1234, 16'h0, 1'b0, 16'h0);
        ocioso(2, 1'b0);
        ciclo(1'b1, 2'b10, 1'b1, 3'd6, 16'h1111, 16'h00A5, 1'b0, 16'h0);
        ocioso(2, 1'b0);

        // Load to r5, response after 4 wait cycles
        ciclo(1'b1, 2'b01, 1'b1, 3'd5, 16'h0, 16'h0, 1'b0, 16'h0);
        ocioso(3, 1'b0);
        ciclo(1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 16'hBEEF);
        ocioso(3, 1'b0);

        // Response on the very last wait cycle wins over the timeout
        ciclo(1'b1, 2'b01, 1'b1, 3'd2, 16'h0, 16'h0, 1'b0, 16'h0);
        ocioso(int'(ESPERA_MAX) - 1, 1'b0);
        ciclo(1'b0, 2'b00, 1'b0, 3'd0, 16'h0, 16'h0, 1'b1, 16'hCAFE);
        ocioso(2, 1'b0);

        // Non-writing instructions are consumed silently
        ciclo(1'b1, 2'b00, 1'b0, 3'd1, 16'h7777, 16'h0, 1'b0, 16'h0);
        ciclo(1'b1, 2'b11, 1'b1, 3'd1, 16'h7777, 16'h0, 1'b0, 16'h0);
        ciclo(1'b1, 2'b01, 1'b0, 3'd1, 16'h7777, 16'h0, 1'b0, 16'h0);
        ocioso(1, 1'b0);

        // Back-to-back ULA ops to r0..r3
        for (int r = 0; r < 4; r++)
            ciclo(1'b1, 2'b00, 1'b1, 3'(r), 16'(16'hA000 + r), 16'h0, 1'b0, 16'h0);
        ocioso(3, 1'b0);

        // Timeout: no response, then a stray MD_pronto is ignored
        ciclo(1'b1, 2'b01, 1'b1, 3'd4, 16'h0, 16'h0, 1'b0, 16'h0);
        ocioso(int'(ESPERA_MAX) + 2, 1'b0);
        ocioso(2, 1'b1);
        ocioso(1, 1'b0);

        // Asynchronous reset in the middle of ESPERA_MD
        ciclo(1'b1, 2'b01, 1'b1, 3'd7, 16'h0, 16'h0, 1'b0, 16'h0);
        ocioso(3, 1'b0);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        verifica("mid_rst_BR_Hab", 32'(bus.BR_Hab_Escrita), 32'd0);
        verifica("mid_rst_BR_Sel", 32'(bus.BR_Sel_E),       32'd0);
        verifica("mid_rst_BR_E",   32'(bus.BR_E),           32'd0);
        verifica("mid_rst_fwd",    32'(bus.fwd_valido),     32'd0);
        verifica("mid_rst_fsel",   32'(bus.fwd_sel),        32'd0);
        verifica("mid_rst_erro",   32'(bus.erro),           32'd0);
        modelo_reset();
        @(negedge clock);
        reset = 1'b1;
        ocioso(2, 1'b1);
        ocioso(2, 1'b0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] ctl;
            ctl = 2'($urandom_range(0, 3));
            ciclo(1'($urandom_range(0, 3) != 0), ctl, 1'($urandom_range(0, 3) != 0),
                  3'($urandom), 16'($urandom), 16'($urandom),
                  1'($urandom_range(0, 7) == 0), 16'($urandom));
        end
        ocioso(int'(ESPERA_MAX) + 3, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
